// File: rtl/floating_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, flush-to-zero on subnormals.
// Combinational core with an optional output register (PIPELINE=1).
module floating_adder #(
   parameter int PIPELINE = 0
) (
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Leading-zero count of a 27-bit value (27 when the value is zero).
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   // mant holds {hidden, 23 fraction, guard, round, sticky}.
   function automatic logic [31:0] round_pack(input logic sign,
                                              input logic signed [9:0] exp,
                                              input logic [26:0] mant);
      logic              inc;
      logic [24:0]       rnd;
      logic signed [9:0] e;
      inc = mant[2] & (mant[1] | mant[0] | mant[3]);
      rnd = {1'b0, mant[26:3]} + {24'b0, inc};
      e   = exp;
      if (rnd[24]) e = e + 10'sd1;
      if (exp <= 10'sd0)   return {sign, 31'b0};
      if (e >= 10'sd255)   return {sign, 8'hFF, 23'b0};
      return {sign, e[7:0], rnd[22:0]};
   endfunction

   logic              sa, sb;
   logic [7:0]        ea, eb;
   logic [22:0]       fa, fb;
   logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

   assign {sa, ea, fa} = op_a;
   assign {sb, eb, fb} = op_b;
   assign nan_a  = (ea == 8'hFF) && (fa != 23'b0);
   assign nan_b  = (eb == 8'hFF) && (fb != 23'b0);
   assign inf_a  = (ea == 8'hFF) && (fa == 23'b0);
   assign inf_b  = (eb == 8'hFF) && (fb == 23'b0);
   assign zero_a = (ea == 8'h00);
   assign zero_b = (eb == 8'h00);

   logic              swap, sl;
   logic [7:0]        el, es, d;
   logic [23:0]       ml, ms;
   logic [49:0]       wide;
   logic [26:0]       large_al, small_al, norm;
   logic [27:0]       raw;
   logic [4:0]        lz;
   logic signed [9:0] en;
   logic [31:0]       sum_p0;
   logic [31:0]       result_p1;

   // stage p0: unpack, align, add, normalize, round
   always_comb begin
      swap     = {eb, fb} > {ea, fa};
      sl       = swap ? sb : sa;
      el       = swap ? eb : ea;
      es       = swap ? ea : eb;
      ml       = {1'b1, swap ? fb : fa};
      ms       = {1'b1, swap ? fa : fb};
      d        = el - es;
      wide     = {ms, 26'b0} >> d;
      large_al = {ml, 3'b000};
      if (d >= 8'd26) small_al = 27'd1;
      else            small_al = {wide[49:24], |wide[23:0]};

      if (sa == sb) raw = {1'b0, large_al} + {1'b0, small_al};
      else          raw = {1'b0, large_al} - {1'b0, small_al};

      lz = lzc27(raw[26:0]);
      en = $signed({2'b00, el});
      if (raw[27]) begin
         norm = {raw[27:2], raw[1] | raw[0]};
         en   = en + 10'sd1;
      end else begin
         norm = raw[26:0] << lz;
         en   = en - $signed({5'b0, lz});
      end

      if (nan_a || nan_b)                   sum_p0 = QNAN;
      else if (inf_a && inf_b && (sa != sb)) sum_p0 = QNAN;
      else if (inf_a)                       sum_p0 = op_a;
      else if (inf_b)                       sum_p0 = op_b;
      else if (zero_a && zero_b)            sum_p0 = {sa & sb, 31'b0};
      else if (zero_a)                      sum_p0 = op_b;
      else if (zero_b)                      sum_p0 = op_a;
      else if (raw == 28'b0)                sum_p0 = 32'h0000_0000;
      else                                  sum_p0 = round_pack(sl, en, norm);
   end

   // stage p1: optional output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result_p1 <= 32'h0000_0000;
      else        result_p1 <= sum_p0;
   end

   assign result = (PIPELINE != 0) ? result_p1 : sum_p0;

endmodule

// File: tb/tb_floating_adder.sv
// Self-checking bench for floating_adder: directed cases, randomized operands
// against a double-precision reference, and registered-mode reset behaviour.
module tb_floating_adder;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] op_a  = 32'h0;
   logic [31:0] op_b  = 32'h0;
   logic [31:0] result_comb, result_reg;
   int          n_checks = 0;
   int          n_pass   = 0;

   floating_adder #(.PIPELINE(0)) u_comb (
      .op_a(op_a), .op_b(op_b), .clk(1'b0), .rst_n(1'b1), .result(result_comb)
   );

   floating_adder #(.PIPELINE(1)) u_reg (
      .op_a(op_a), .op_b(op_b), .clk(clk), .rst_n(rst_n), .result(result_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference: exact IEEE double addition, then RNE narrowing to single with flush-to-zero.
   function automatic real to_real(input logic [31:0] x);
      if (x[30:23] == 8'h00) return $bitstoreal({x[31], 63'b0});
      return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0});
   endfunction

   function automatic logic [31:0] from_real(input real r);
      logic [63:0] bits;
      logic [30:0] mag;
      int          e;
      bits = $realtobits(r);
      if (bits[62:52] == 11'd0) return {bits[63], 31'b0};
      e = int'({21'b0, bits[62:52]}) - 896;
      if (e <= 0)   return {bits[63], 31'b0};
      if (e >= 255) return {bits[63], 8'hFF, 23'b0};
      mag = {e[7:0], bits[51:29]};
      if (bits[28:0] > 29'h1000_0000 || (bits[28:0] == 29'h1000_0000 && bits[29]))
         mag = mag + 31'd1;
      return {bits[63], mag};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic xnan, ynan, xinf, yinf;
      xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xnan || ynan)                     return QNAN;
      if (xinf && yinf && (x[31] != y[31])) return QNAN;
      if (xinf)                             return x;
      if (yinf)                             return y;
      return from_real(to_real(x) + to_real(y));
   endfunction

   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      op_a = a; op_b = b;
      #1 check(tag, result_comb, exp);
      op_a = b; op_b = a;
      #1 check({tag, "_swap"}, result_comb, exp);
   endtask

   function automatic logic [31:0] rand_operand(input int kind);
      logic [31:0] v;
      v = $urandom;
      case (kind)
         1: v[30:23] = 8'($urandom_range(135, 118));
         2: v[30:23] = ($urandom_range(1, 0) != 0) ? 8'hFF : 8'h00;
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      // asynchronous reset takes effect with no clock edge
      #1 rst_n = 1'b0;
      #1 check("reset_async", result_reg, 32'h0);

      directed("cancel",      32'hBF4C_CCCD, 32'h3F4C_CCCD, 32'h0000_0000);
      directed("sub_norm",    32'h3F99_999A, 32'hBF4C_CCCD, 32'h3ECC_CCCE);
      directed("carry",       32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
      directed("tie_even",    32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      directed("tie_up",      32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
      directed("inf_minf",    32'h7F80_0000, 32'hFF80_0000, QNAN);
      directed("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
      directed("neg_zeros",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      directed("mixed_zeros", 32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
      directed("subnormal",   32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
      directed("nan_in",      32'h7F80_0001, 32'h3F80_0000, QNAN);
      directed("inf_finite",  32'hFF80_0000, 32'h4120_0000, 32'hFF80_0000);
      directed("zero_plus_x", 32'h0000_0000, 32'hC0A0_0000, 32'hC0A0_0000);
      directed("underflow",   32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
      check("reset_hold", result_reg, 32'h0);

      // release reset away from the edge; first edge loads the current sum
      @(negedge clk);
      op_a = 32'h3F80_0000; op_b = 32'h3F80_0000;
      rst_n = 1'b1;
      @(posedge clk); #1 check("reg_first", result_reg, 32'h4000_0000);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b, exp;
         int          kind;
         @(negedge clk);
         kind = $urandom_range(3, 0);
         a = rand_operand(kind);
         b = rand_operand(kind == 2 ? $urandom_range(2, 0) : kind);
         if (kind == 3) b = {~a[31], a[30:0] ^ 31'($urandom_range(15, 0))};
         exp = ref_add(a, b);
         op_a = b; op_b = a;
         #1 check("rand_swap", result_comb, exp);
         op_a = a; op_b = b;
         #1 check("rand_comb", result_comb, exp);
         @(posedge clk); #1 check("rand_reg", result_reg, exp);
      end

      // reset mid-stream drops the registered value immediately and holds it
      @(negedge clk);
      op_a = 32'h4040_0000; op_b = 32'h3F80_0000;
      @(posedge clk); #1 check("reg_pre", result_reg, 32'h4080_0000);
      #2 rst_n = 1'b0;
      #1 check("reg_mid_reset", result_reg, 32'h0);
      @(posedge clk); #1 check("reg_reset_hold", result_reg, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1 check("reg_after_reset", result_reg, 32'h4080_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
